// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-arithmetic request arbiters.
//   idx_bits() : width of a requester index, never less than 1 bit.
//   sub_req_t  : operand pair plus requester control, at the default widths.
package mod_arith_pkg;

    localparam int SUB_BITS  = 381;
    localparam int SUB_CTL_W = 8;

    // A single-requester index still needs one bit, so the tag field never vanishes.
    function automatic int idx_bits(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [SUB_BITS-1:0]  a;
        logic [SUB_BITS-1:0]  b;
        logic [SUB_CTL_W-1:0] ctl;
    } sub_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : index that gets highest priority this cycle
//   o_gnt : one-hot grant (zero when nothing requests)
//   o_idx : index of the granted requester
//   o_any : at least one request is present
module rr_arbiter
    import mod_arith_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_bits(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    localparam int CW = IW + 1;

    logic [CW-1:0] cand;

    // Walk ptr, ptr+1, ... wrapping at N; the first requester seen wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, i_ptr} + CW'(k);
            if (cand >= CW'(N)) cand = cand - CW'(N);
            if (!o_any && i_req[cand[IW-1:0]]) begin
                o_any               = 1'b1;
                o_idx               = cand[IW-1:0];
                o_gnt[cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_sub_arb.sv
// Shares one pipelined modular subtractor between NUM_IN requesters.
//   i_val/i_dat_a/i_dat_b/i_ctl, o_rdy : requester issue side (o_rdy = grant)
//   o_val/o_dat/o_ctl, i_rdy           : requester response side (o_val one-hot)
//   o_sub_val/o_sub_dat_a/o_sub_dat_b/o_sub_ctl, i_sub_rdy : issue to subtractor
//   i_sub_val/i_sub_dat/i_sub_ctl, o_sub_rdy              : results from subtractor
//   o_inflight : accepted-but-not-returned operation count
// The requester index rides in the top bits of o_sub_ctl and steers the result back.
module mod_sub_arb
    import mod_arith_pkg::*;
#(
    parameter  int NUM_IN       = 4,
    parameter  int BITS         = 381,
    parameter  int CTL_BITS     = 8,
    parameter  int MAX_INFLIGHT = 8,
    localparam int IDX_BITS     = idx_bits(NUM_IN),
    localparam int SUB_CTL_BITS = CTL_BITS + IDX_BITS,
    localparam int CNT_BITS     = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_IN-1:0]                i_val,
    input  logic [NUM_IN-1:0][BITS-1:0]      i_dat_a,
    input  logic [NUM_IN-1:0][BITS-1:0]      i_dat_b,
    input  logic [NUM_IN-1:0][CTL_BITS-1:0]  i_ctl,
    output logic [NUM_IN-1:0]                o_rdy,
    output logic [NUM_IN-1:0]                o_val,
    output logic [BITS-1:0]                  o_dat,
    output logic [CTL_BITS-1:0]              o_ctl,
    input  logic [NUM_IN-1:0]                i_rdy,
    output logic                             o_sub_val,
    output logic [BITS-1:0]                  o_sub_dat_a,
    output logic [BITS-1:0]                  o_sub_dat_b,
    output logic [SUB_CTL_BITS-1:0]          o_sub_ctl,
    input  logic                             i_sub_rdy,
    input  logic                             i_sub_val,
    input  logic [BITS-1:0]                  i_sub_dat,
    input  logic [SUB_CTL_BITS-1:0]          i_sub_ctl,
    output logic                             o_sub_rdy,
    output logic [CNT_BITS-1:0]              o_inflight
);

    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] win_idx;
    logic [NUM_IN-1:0]   win_gnt;
    logic                any_val;
    logic                stage_free;
    logic                load_en;
    logic                grant;
    logic                retire;
    logic [IDX_BITS-1:0] rsp_idx;
    logic [CNT_BITS-1:0] cnt;

    rr_arbiter #(.N(NUM_IN)) u_arb (
        .i_req (i_val),
        .i_ptr (rr_ptr),
        .o_gnt (win_gnt),
        .o_idx (win_idx),
        .o_any (any_val)
    );

    // Credit check is deliberately on the registered count: a response retiring
    // in the same cycle does not free a slot until the next cycle.
    assign stage_free = ~o_sub_val | i_sub_rdy;
    assign load_en    = stage_free & (cnt < CNT_BITS'(MAX_INFLIGHT)) & ~i_rst;
    assign grant      = load_en & any_val;
    assign o_rdy      = grant ? win_gnt : '0;

    // Response steering is purely combinational.
    assign rsp_idx   = i_sub_ctl[SUB_CTL_BITS-1 -: IDX_BITS];
    assign o_dat     = i_sub_dat;
    assign o_ctl     = i_sub_ctl[CTL_BITS-1:0];
    assign o_sub_rdy = ~i_sub_val | i_rdy[rsp_idx];
    assign retire    = i_sub_val & o_sub_rdy;
    assign o_inflight = cnt;

    always_comb begin
        o_val          = '0;
        o_val[rsp_idx] = i_sub_val;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sub_val   <= 1'b0;
            o_sub_dat_a <= '0;
            o_sub_dat_b <= '0;
            o_sub_ctl   <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
        end else begin
            if (grant) begin
                o_sub_val   <= 1'b1;
                o_sub_dat_a <= i_dat_a[win_idx];
                o_sub_dat_b <= i_dat_b[win_idx];
                o_sub_ctl   <= {win_idx, i_ctl[win_idx]};
                rr_ptr      <= (win_idx == IDX_BITS'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
            end else if (stage_free) begin
                // Also drains when credits are exhausted, so an accepted
                // operation is never presented to the subtractor twice.
                o_sub_val <= 1'b0;
            end
            if (grant && !retire)
                cnt <= cnt + 1'b1;
            else if (!grant && retire && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_mod_sub_arb.sv
// Randomised + directed bench for mod_sub_arb with a modulus-13, latency-2
// subtractor stand-in and a behavioural model checked on every cycle.
module tb_mod_sub_arb;

    localparam int NUM_IN = 4, BITS = 381, CTL_BITS = 8, MAX_INFLIGHT = 8;
    localparam int IDX_BITS = 2, SUB_CTL_BITS = 10, CNT_BITS = 4;
    localparam int P = 13, LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_IN-1:0]               i_val = '0;
    logic [NUM_IN-1:0][BITS-1:0]     i_dat_a = '0;
    logic [NUM_IN-1:0][BITS-1:0]     i_dat_b = '0;
    logic [NUM_IN-1:0][CTL_BITS-1:0] i_ctl = '0;
    logic [NUM_IN-1:0]               o_rdy, o_val;
    logic [BITS-1:0]                 o_dat;
    logic [CTL_BITS-1:0]             o_ctl;
    logic [NUM_IN-1:0]               i_rdy = '1;
    logic                            o_sub_val;
    logic [BITS-1:0]                 o_sub_dat_a, o_sub_dat_b;
    logic [SUB_CTL_BITS-1:0]         o_sub_ctl;
    logic                            i_sub_rdy = 1'b1;
    logic                            i_sub_val = 1'b0;
    logic [BITS-1:0]                 i_sub_dat = '0;
    logic [SUB_CTL_BITS-1:0]         i_sub_ctl = '0;
    logic                            o_sub_rdy;
    logic [CNT_BITS-1:0]             o_inflight;

    always #5 clk = ~clk;

    mod_sub_arb #(.NUM_IN(NUM_IN), .BITS(BITS), .CTL_BITS(CTL_BITS), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .i_clk(clk), .i_rst(rst), .i_val(i_val), .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .i_ctl(i_ctl),
        .o_rdy(o_rdy), .o_val(o_val), .o_dat(o_dat), .o_ctl(o_ctl), .i_rdy(i_rdy),
        .o_sub_val(o_sub_val), .o_sub_dat_a(o_sub_dat_a), .o_sub_dat_b(o_sub_dat_b), .o_sub_ctl(o_sub_ctl),
        .i_sub_rdy(i_sub_rdy), .i_sub_val(i_sub_val), .i_sub_dat(i_sub_dat), .i_sub_ctl(i_sub_ctl),
        .o_sub_rdy(o_sub_rdy), .o_inflight(o_inflight)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [BITS-1:0] mod_sub(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        return (a + BITS'(P) - b) % BITS'(P);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- subtractor stand-in: in-order, LAT cycles, mod P ----------------
    typedef struct { logic [BITS-1:0] d; logic [SUB_CTL_BITS-1:0] c; int due; } pipe_t;
    pipe_t pq[$];
    int cyc = 0;
    bit env_acc, env_ret, env_rst;
    logic [BITS-1:0] env_a, env_b;
    logic [SUB_CTL_BITS-1:0] env_c;

    always @(negedge clk) begin
        env_acc = o_sub_val && i_sub_rdy;
        env_ret = i_sub_val && o_sub_rdy;
        env_rst = rst;
        env_a = o_sub_dat_a;
        env_b = o_sub_dat_b;
        env_c = o_sub_ctl;
    end

    always @(posedge clk) begin
        pipe_t e;
        #1;
        cyc++;
        if (env_rst) pq.delete();
        else begin
            if (env_ret && pq.size() > 0) void'(pq.pop_front());
            if (env_acc) begin
                e.d = (env_a >= env_b) ? env_a - env_b : env_a + BITS'(P) - env_b;
                e.c = env_c;
                e.due = cyc + LAT;
                pq.push_back(e);
            end
        end
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            i_sub_val = 1'b1; i_sub_dat = pq[0].d; i_sub_ctl = pq[0].c;
        end else begin
            i_sub_val = 1'b0; i_sub_dat = '0; i_sub_ctl = '0;
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct { logic [BITS-1:0] d; logic [CTL_BITS-1:0] c; } rsp_t;
    typedef struct { int idx; logic [BITS-1:0] d; } log_t;
    rsp_t sb[NUM_IN][$];
    log_t rsp_log[$];
    int   gnt_log[$];
    logic [NUM_IN-1:0] last_gnt = '0;

    int m_ptr = 0, m_cnt = 0;
    logic m_sval = 1'b0;
    logic [BITS-1:0] m_sa = '0, m_sb = '0;
    logic [SUB_CTL_BITS-1:0] m_sctl = '0;

    always @(negedge clk) begin
        bit adv, le, e_srdy;
        int win, ridx;
        logic [NUM_IN-1:0] e_rdy, e_val;
        rsp_t r;
        log_t l;
        check("sub_val", o_sub_val, m_sval);
        check("sub_a", o_sub_dat_a, m_sa);
        check("sub_b", o_sub_dat_b, m_sb);
        check("sub_ctl", o_sub_ctl, m_sctl);
        check("inflight", o_inflight, m_cnt);
        adv = !m_sval || i_sub_rdy;
        le  = adv && (m_cnt < MAX_INFLIGHT) && !rst;
        win = -1;
        for (int k = 0; k < NUM_IN; k++)
            if (win < 0 && i_val[(m_ptr + k) % NUM_IN]) win = (m_ptr + k) % NUM_IN;
        e_rdy = '0;
        if (le && win >= 0) e_rdy[win] = 1'b1;
        ridx = int'(i_sub_ctl[SUB_CTL_BITS-1 -: IDX_BITS]);
        assert (!i_sub_val || ridx < NUM_IN) else $error("illegal response index %0d", ridx);
        e_val = '0; e_srdy = 1'b1;
        if (i_sub_val) begin e_val[ridx] = 1'b1; e_srdy = i_rdy[ridx]; end
        check("o_rdy", o_rdy, e_rdy);
        check("o_val", o_val, e_val);
        check("o_sub_rdy", o_sub_rdy, e_srdy);
        if (i_sub_val) begin
            check("o_dat", o_dat, i_sub_dat);
            check("o_ctl", o_ctl, i_sub_ctl[CTL_BITS-1:0]);
        end
        last_gnt = o_rdy;
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_sval = 1'b0; m_sa = '0; m_sb = '0; m_sctl = '0;
            for (int i = 0; i < NUM_IN; i++) sb[i].delete();
        end else begin
            if (win >= 0 && le) begin
                gnt_log.push_back(win);
                r.d = mod_sub(i_dat_a[win], i_dat_b[win]);
                r.c = i_ctl[win];
                sb[win].push_back(r);
                m_sval = 1'b1; m_sa = i_dat_a[win]; m_sb = i_dat_b[win];
                m_sctl = {IDX_BITS'(win), i_ctl[win]};
                m_ptr = (win + 1) % NUM_IN;
                m_cnt++;
            end else if (adv) m_sval = 1'b0;
            if (i_sub_val && e_srdy) begin
                if (m_cnt > 0) m_cnt--;
                l.idx = ridx; l.d = o_dat;
                rsp_log.push_back(l);
                if (sb[ridx].size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_unexpected: response to %0d with no outstanding request", ridx);
                end else begin
                    r = sb[ridx].pop_front();
                    check("sb_dat", o_dat, r.d);
                    check("sb_ctl", o_ctl, r.c);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int gl0, rl0, n;
    logic [BITS-1:0] sa, sbv;
    logic [SUB_CTL_BITS-1:0] sc;

    task automatic drain(input int cycles);
        i_val = '0; i_rdy = '1; i_sub_rdy = 1'b1;
        repeat (cycles) tick();
    endtask

    initial begin
        // reset state; o_rdy must stay low even with requests present
        repeat (3) tick();
        i_val = '1;
        #1;
        check("rst_rdy", o_rdy, 0);
        check("rst_sub_val", o_sub_val, 0);
        check("rst_sub_a", o_sub_dat_a, 0);
        check("rst_sub_ctl", o_sub_ctl, 0);
        check("rst_inflight", o_inflight, 0);
        i_val = '0;
        rst = 1'b0;
        tick();

        // full contention: 8 grants rotate 0..3 twice, each 3-5 mod 13 = 11
        gl0 = gnt_log.size(); rl0 = rsp_log.size();
        for (int i = 0; i < NUM_IN; i++) begin
            i_dat_a[i] = 3; i_dat_b[i] = 5; i_ctl[i] = CTL_BITS'(8'h10 + i);
        end
        i_val = '1;
        repeat (8) tick();
        i_val = '0;
        check("fc_grants", gnt_log.size() - gl0, 8);
        for (int k = 0; k < 8; k++) check($sformatf("fc_order%0d", k), gnt_log[gl0 + k], k % 4);
        drain(8);
        check("fc_rsps", rsp_log.size() - rl0, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fc_rsp_idx%0d", k), rsp_log[rl0 + k].idx, k % 4);
            check($sformatf("fc_rsp_dat%0d", k), rsp_log[rl0 + k].d, 11);
        end

        // single requester 2: 10-3 = 7
        i_val[2] = 1'b1; i_dat_a[2] = 10; i_dat_b[2] = 3; i_ctl[2] = 8'h5A;
        tick();
        i_val = '0;
        check("t1_sub_val", o_sub_val, 1);
        check("t1_sub_idx", o_sub_ctl[SUB_CTL_BITS-1 -: IDX_BITS], 2);
        check("t1_sub_ctl", o_sub_ctl[CTL_BITS-1:0], 8'h5A);
        n = 0;
        while (o_val == '0 && n < 10) begin tick(); n++; end
        check("t1_timeout", n < 10, 1);
        check("t1_val", o_val, 4'b0100);
        check("t1_dat", o_dat, 7);
        check("t1_ctl", o_ctl, 8'h5A);
        drain(4);

        // pointer wrap: pointer now 3, requests from 0 and 3
        gl0 = gnt_log.size();
        i_dat_a[0] = 12; i_dat_b[0] = 1; i_dat_a[3] = 0; i_dat_b[3] = 12;
        i_val = 4'b1001;
        tick(); i_val &= ~last_gnt;
        tick(); i_val &= ~last_gnt;
        i_val = '1;
        tick();
        i_val = '0;
        check("wrap_grants", gnt_log.size() - gl0, 3);
        check("wrap_first", gnt_log[gl0], 3);
        check("wrap_second", gnt_log[gl0 + 1], 0);
        check("wrap_ptr_next", gnt_log[gl0 + 2], 1);
        drain(6);

        // backpressure: stage holds while the subtractor stalls
        i_val = '1; i_sub_rdy = 1'b0;
        tick();
        i_val &= ~last_gnt;
        gl0 = gnt_log.size();
        sa = o_sub_dat_a; sbv = o_sub_dat_b; sc = o_sub_ctl;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_val", o_sub_val, 1);
            check("bp_a", o_sub_dat_a, sa);
            check("bp_b", o_sub_dat_b, sbv);
            check("bp_ctl", o_sub_ctl, sc);
            check("bp_rdy", o_rdy, 0);
        end
        check("bp_no_grant", gnt_log.size() - gl0, 0);
        i_sub_rdy = 1'b1;

        // random traffic with random backpressure on both sides
        for (int c = 0; c < 600; c++) begin
            tick();
            i_val &= ~last_gnt;
            for (int i = 0; i < NUM_IN; i++) begin
                if (!i_val[i] && $urandom_range(0, 2) == 0) begin
                    i_val[i] = 1'b1;
                    i_dat_a[i] = BITS'($urandom_range(0, P - 1));
                    i_dat_b[i] = BITS'($urandom_range(0, P - 1));
                    i_ctl[i] = CTL_BITS'($urandom);
                end
                i_rdy[i] = ($urandom_range(0, 3) != 0);
            end
            i_sub_rdy = ($urandom_range(0, 3) != 0);
        end
        drain(20);
        check("rand_drained", o_inflight, 0);

        // credit limit: responses blocked, grants stop at MAX_INFLIGHT
        gl0 = gnt_log.size();
        i_rdy = '0; i_val = '1;
        repeat (14) tick();
        check("cr_grants", gnt_log.size() - gl0, MAX_INFLIGHT);
        check("cr_inflight", o_inflight, MAX_INFLIGHT);
        check("cr_rdy", o_rdy, 0);
        check("cr_rsp_pending", o_val != '0, 1);
        i_rdy = o_val;
        tick();
        i_rdy = '0;
        check("cr_dec", o_inflight, MAX_INFLIGHT - 1);
        check("cr_no_same_cycle_grant", gnt_log.size() - gl0, MAX_INFLIGHT);
        tick();
        check("cr_regrant", gnt_log.size() - gl0, MAX_INFLIGHT + 1);
        check("cr_full_again", o_inflight, MAX_INFLIGHT);
        drain(30);

        // reset mid-stream with three in flight and the stage loaded
        i_rdy = '0; i_val = '1;
        repeat (3) tick();
        i_val = '0; i_sub_rdy = 1'b0;
        check("mr_inflight", o_inflight, 3);
        check("mr_stage", o_sub_val, 1);
        rst = 1'b1; i_val = 4'b0110;
        tick();
        check("mr_sub_val", o_sub_val, 0);
        check("mr_inflight0", o_inflight, 0);
        check("mr_rdy", o_rdy, 0);
        rst = 1'b0; i_sub_rdy = 1'b1;
        gl0 = gnt_log.size();
        tick();
        i_val &= ~last_gnt;
        check("mr_grants", gnt_log.size() - gl0, 1);
        check("mr_first", gnt_log[gl0], 1);
        drain(15);
        check("end_inflight", o_inflight, 0);
        for (int i = 0; i < NUM_IN; i++) check($sformatf("end_sb%0d", i), sb[i].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
